ntt_job_arbiter: RTL and testbench

// - Shares one NTT_wrapper instance between N_REQ requesters, for example the keygen, enc and dec sequencers inside LOM.
// - Arbitrates the pending jobs round-robin and issues a one-cycle run to the wrapper.
// - Holds the job's mode and polynomial index stable while the job runs.
// - Waits for the wrapper's done, then returns a completion pulse to the requester that owns the job.

---
 rtl/ntt_job_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_ntt_job_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_job_arbiter.sv
// -----------------------------------------------------------------------------
// ntt_job_arbiter
//
// Purpose:
//   Shares a single NTT_wrapper between N_REQ requesters (e.g. the keygen, enc
//   and dec sequencers). Pending jobs are arbitrated round-robin. The winning
//   job's mode and polynomial index are latched and held stable for the whole
//   job. The wrapper is started with a one-cycle run pulse. The arbiter waits
//   for the wrapper's done and then returns a one-cycle completion pulse to the
//   requester that owns the job.
//
// Optional feature:
//   NTT_WDOG_EN - when defined, a watchdog counts WAIT cycles. If WDOG_CYC
//                 cycles pass without ntt_done_i, the arbiter sets the sticky
//                 err_o and retires the job, so the owner still gets done_o.
//                 When undefined, err_o is tied to 0 and WAIT has no time limit.
//
// Ports:
//   clk_i       in   clock, rising edge
//   rst_n_i     in   asynchronous active-low reset
//   req_i       in   [N_REQ]         level-held job request per requester
//   mode_i      in   [N_REQ*MODE_W]  per-requester mode; field r at r*MODE_W
//   idx_i       in   [N_REQ*IDX_W]   per-requester poly index; field r at r*IDX_W
//   gnt_o       out  [N_REQ]         one-hot owner, high from ISSUE through RETIRE
//   done_o      out  [N_REQ]         one-cycle completion pulse to the owner
//   ntt_run_o   out                  one-cycle start pulse to the wrapper
//   ntt_mode_o  out  [MODE_W]        registered mode of the current/last job
//   ntt_idx_o   out  [IDX_W]         registered poly index of the current/last job
//   ntt_done_i  in                   wrapper completion
//   busy_o      out                  high whenever the FSM is not IDLE
//   err_o       out                  sticky watchdog error
// -----------------------------------------------------------------------------
module ntt_job_arbiter #(
    parameter int N_REQ    = 3,
    parameter int MODE_W   = 2,
    parameter int IDX_W    = 2,
    parameter int WDOG_CYC = 4096
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*MODE_W-1:0]   mode_i,
    input  logic [N_REQ*IDX_W-1:0]    idx_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          done_o,
    output logic                      ntt_run_o,
    output logic [MODE_W-1:0]         ntt_mode_o,
    output logic [IDX_W-1:0]          ntt_idx_o,
    input  logic                      ntt_done_i,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETIRE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               run_q, run_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;

`ifdef NTT_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYC + 1);
    logic [CNT_W-1:0]   wdog_q, wdog_d;
    logic               err_q, err_d;
`endif

    // -------------------------------------------------------------------------
    // Round-robin candidate list: slot gi holds requester (rr + gi) mod N_REQ.
    // The wrap is an explicit compare-and-subtract so a non-power-of-two N_REQ
    // never produces an index outside 0..N_REQ-1.
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_req;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [PTR_W:0] sum;
            assign sum           = {1'b0, rr_q} + (PTR_W+1)'(gi);
            assign cand_idx[gi]  = (sum >= (PTR_W+1)'(N_REQ))
                                   ? PTR_W'(sum - (PTR_W+1)'(N_REQ))
                                   : sum[PTR_W-1:0];
            assign cand_req[gi]  = req_i[cand_idx[gi]];
        end
    endgenerate

    // First requesting slot wins; scanning downwards lets the lowest slot
    // overwrite any later one.
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        run_d   = 1'b0;
        mode_d  = mode_q;
        idx_d   = idx_q;
`ifdef NTT_WDOG_EN
        wdog_d  = wdog_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ISSUE;
                    owner_d = pick_idx;
                    mode_d  = mode_i[pick_idx*MODE_W +: MODE_W];
                    idx_d   = idx_i[pick_idx*IDX_W +: IDX_W];
                    gnt_d   = ONE_HOT0 << pick_idx;
                    run_d   = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef NTT_WDOG_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                if (ntt_done_i) begin
                    state_d = RETIRE;
                    done_d  = ONE_HOT0 << owner_q;
                end
`ifdef NTT_WDOG_EN
                else if (wdog_q == CNT_W'(WDOG_CYC)) begin
                    // Wrapper never answered: flag it and release the owner.
                    state_d = RETIRE;
                    done_d  = ONE_HOT0 << owner_q;
                    err_d   = 1'b1;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
                end
`endif
            end
            RETIRE: begin
                state_d = IDLE;
                gnt_d   = '0;
                rr_d    = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            run_q   <= 1'b0;
            mode_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
`ifdef NTT_WDOG_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            run_q   <= run_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
`ifdef NTT_WDOG_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    assign gnt_o      = gnt_q;
    assign done_o     = done_q;
    assign ntt_run_o  = run_q;
    assign ntt_mode_o = mode_q;
    assign ntt_idx_o  = idx_q;
    assign busy_o     = busy_q;
`ifdef NTT_WDOG_EN
    assign err_o      = err_q;
`else
    assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ntt_job_arbiter
//
// Directed bench for ntt_job_arbiter with N_REQ = 3. The driver issues
// requests and wrapper-done pulses. For each one it pushes the hand-computed
// expected run/done event, including the cycle it must appear in, onto a
// scoreboard queue. A separate monitor pops the queue whenever the DUT shows
// ntt_run_o or done_o. The monitor also checks that gnt/mode/idx stay fixed
// for the whole job and that gnt drops right after RETIRE.
// Requester fields: mode = {2, 1, 3}, idx = {3, 2, 1} for requesters {2, 1, 0}.
// -----------------------------------------------------------------------------
module tb_ntt_job_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [5:0] mode_v;
    logic [5:0] idx_v;
    logic [2:0] gnt_o;
    logic [2:0] done_o;
    logic       ntt_run_o;
    logic [1:0] ntt_mode_o;
    logic [1:0] ntt_idx_o;
    logic       ntt_done;
    logic       busy_o;
    logic       err_o;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [2:0] oh;
        logic [1:0] mode;
        logic [1:0] idx;
        int         at;
    } exp_t;

    exp_t exp_run[$];
    exp_t exp_done[$];

    ntt_job_arbiter #(
        .N_REQ    (3),
        .MODE_W   (2),
        .IDX_W    (2),
        .WDOG_CYC (16)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_i      (req),
        .mode_i     (mode_v),
        .idx_i      (idx_v),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .ntt_run_o  (ntt_run_o),
        .ntt_mode_o (ntt_mode_o),
        .ntt_idx_o  (ntt_idx_o),
        .ntt_done_i (ntt_done),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("[%0d] check %s: got %0h", cyc, name, act);
        end else begin
            $display("[%0d] FAIL %s: got %0h expected %0h", cyc, name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input logic [2:0] oh, input logic [1:0] m, input logic [1:0] i, input int at);
        exp_t e;
        e.oh = oh; e.mode = m; e.idx = i; e.at = at;
        exp_run.push_back(e);
    endtask

    task automatic push_done(input logic [2:0] oh, input int at);
        exp_t e;
        e.oh = oh; e.mode = '0; e.idx = '0; e.at = at;
        exp_done.push_back(e);
    endtask

    // Pulse the wrapper done (two cycles: the second one lands in RETIRE and
    // must be ignored). Optionally drop the owner's request in the cycle after
    // done_o. Returns two cycles after the pulse started, in IDLE.
    task automatic finish_job(input logic [2:0] owner, input bit drop);
        int q;
        q = cyc;
        ntt_done = 1'b1;
        push_done(owner, q + 1);
        tick();
        tick();
        ntt_done = 1'b0;
        if (drop) req = req & ~owner;
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin
        exp_t cur;
        exp_t d;
        bit   in_job = 0;
        bit   hold_bad = 0;
        bit   chk_drop = 0;
        bit   have_last = 0;
        int   last_run = 0;
        cur.oh = '0; cur.mode = '0; cur.idx = '0; cur.at = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_job   = 0;
                chk_drop = 0;
            end else begin
                if (chk_drop) begin
                    chk("gnt_drop", 32'(gnt_o), 32'd0);
                    chk_drop = 0;
                end
                if (ntt_run_o) begin
                    if (exp_run.size() == 0) begin
                        n_checks++;
                        $display("[%0d] FAIL run_unexpected: got gnt %0h expected no run", cyc, gnt_o);
                    end else begin
                        cur = exp_run.pop_front();
                        chk("run_cycle", 32'(cyc), 32'(cur.at));
                        chk("run_gnt", 32'(gnt_o), 32'(cur.oh));
                        chk("run_mode", 32'(ntt_mode_o), 32'(cur.mode));
                        chk("run_idx", 32'(ntt_idx_o), 32'(cur.idx));
                        if (have_last) chk("run_spacing_ge3", 32'(cyc - last_run >= 3), 32'd1);
                        last_run  = cyc;
                        have_last = 1;
                        in_job    = 1;
                        hold_bad  = 0;
                    end
                end else if (in_job) begin
                    if (gnt_o !== cur.oh || ntt_mode_o !== cur.mode || ntt_idx_o !== cur.idx)
                        hold_bad = 1;
                end
                if (done_o != 3'b000) begin
                    if (exp_done.size() == 0) begin
                        n_checks++;
                        $display("[%0d] FAIL done_unexpected: got done %0h expected none", cyc, done_o);
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_val", 32'(done_o), 32'(d.oh));
                        chk("done_cycle", 32'(cyc), 32'(d.at));
                        if (in_job) chk("job_hold", 32'(hold_bad), 32'd0);
                        in_job   = 0;
                        chk_drop = 1;
                    end
                end
            end
        end
    end

    // ----------------------------------------------------------------- driver
    initial begin
        int p;
        rst_n    = 1'b0;
        req      = 3'b000;
        ntt_done = 1'b0;
        mode_v   = {2'd2, 2'd1, 2'd3};
        idx_v    = {2'd3, 2'd2, 2'd1};
        repeat (3) tick();

        // Reset state
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_run", 32'(ntt_run_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_mode", 32'(ntt_mode_o), 32'd0);
        chk("rst_idx", 32'(ntt_idx_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single job for requester 1, wrapper done 300 cycles after run
        p = cyc;
        req = 3'b010;
        push_run(3'b010, 2'd1, 2'd2, p + 1);
        tick();
        chk("busy_issue", 32'(busy_o), 32'd1);
        ntt_done = 1'b1;            // lands in ISSUE: must be ignored
        tick();
        ntt_done = 1'b0;
        repeat (3) tick();
        mode_v[3:2] = 2'd3;         // late field changes must not reach the job
        idx_v[3:2]  = 2'd0;
        while (cyc < p + 301) tick();
        finish_job(3'b010, 1);
        mode_v[3:2] = 2'd1;
        idx_v[3:2]  = 2'd2;
        tick();
        chk("busy_idle", 32'(busy_o), 32'd0);

        // Spurious wrapper done while IDLE
        ntt_done = 1'b1;
        repeat (3) tick();
        ntt_done = 1'b0;
        tick();
        chk("idle_spur_busy", 32'(busy_o), 32'd0);
        chk("idle_spur_idx", 32'(ntt_idx_o), 32'd2);
        chk("idle_spur_mode", 32'(ntt_mode_o), 32'd1);

        // Contention: all requests held from reset, order 0, 1, 2
        rst_n = 1'b0;
        req   = 3'b111;
        tick();
        tick();
        p = cyc;
        push_run(3'b001, 2'd3, 2'd1, p + 1);
        rst_n = 1'b1;
        repeat (5) tick();
        finish_job(3'b001, 1);
        push_run(3'b010, 2'd1, 2'd2, cyc + 1);
        repeat (5) tick();
        finish_job(3'b010, 1);
        push_run(3'b100, 2'd2, 2'd3, cyc + 1);
        repeat (5) tick();
        finish_job(3'b100, 1);
        repeat (4) tick();

        // Fairness: requester 0 keeps asking, requester 2 must come second
        p = cyc;
        req = 3'b101;
        push_run(3'b001, 2'd3, 2'd1, p + 1);
        repeat (5) tick();
        finish_job(3'b001, 0);
        push_run(3'b100, 2'd2, 2'd3, cyc + 1);
        repeat (5) tick();
        finish_job(3'b100, 1);
        push_run(3'b001, 2'd3, 2'd1, cyc + 1);   // rr wrapped 2 -> 0
        repeat (5) tick();
        finish_job(3'b001, 1);
        repeat (3) tick();

        // Request dropped during WAIT still completes
        p = cyc;
        req = 3'b001;
        push_run(3'b001, 2'd3, 2'd1, p + 1);
        repeat (3) tick();
        req = 3'b000;
        repeat (4) tick();
        finish_job(3'b001, 0);
        repeat (3) tick();

        // Reset in the middle of a job (rr is 1 beforehand)
        p = cyc;
        req = 3'b100;
        push_run(3'b100, 2'd2, 2'd3, p + 1);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_mode", 32'(ntt_mode_o), 32'd0);
        chk("midrst_idx", 32'(ntt_idx_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        tick();
        tick();
        req = 3'b101;               // rr back at 0 picks requester 0
        push_run(3'b001, 2'd3, 2'd1, cyc + 1);
        rst_n = 1'b1;
        repeat (5) tick();
        finish_job(3'b001, 1);
        push_run(3'b100, 2'd2, 2'd3, cyc + 1);
        repeat (5) tick();
        finish_job(3'b100, 1);
        repeat (3) tick();

`ifdef NTT_WDOG_EN
        // Watchdog: no wrapper done; retire on the 17th cycle after WAIT entry
        chk("wdog_err_before", 32'(err_o), 32'd0);
        p = cyc;
        req = 3'b010;
        push_run(3'b010, 2'd1, 2'd2, p + 1);
        push_done(3'b010, p + 19);
        repeat (20) tick();
        chk("wdog_err", 32'(err_o), 32'd1);
        req = 3'b001;
        push_run(3'b001, 2'd3, 2'd1, cyc + 1);
        repeat (5) tick();
        finish_job(3'b001, 1);
        repeat (3) tick();
        chk("wdog_err_sticky", 32'(err_o), 32'd1);
`else
        chk("err_tied", 32'(err_o), 32'd0);
`endif

        chk("run_queue_empty", 32'(exp_run.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
